tt_pin_exerciser: RTL and testbench

- On-chip self-test driver for the Tiny Tapeout user pin interface: it plays the host side of the `ui_in`/`uo_out` boundary.
- It generates a pseudo-random 8-bit stimulus stream for a user project's dedicated inputs and compresses the project's dedicated outputs into a 16-bit MISR signature.
- It sits in a test wrapper next to the user project, so a single pin-level run yields one pass/fail signature without an external cocotb bench.

---
 rtl/tt_pin_exerciser.sv | 153 +++++++++++++++
 tb/tb_tt_pin_exerciser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_pin_exerciser.sv
// Host-side self-test driver for the Tiny Tapeout user pins: LFSR stimulus on ui_in, MISR signature of uo_out.
// Optional macro PIN_EXERCISER_UIO_EN adds the bidirectional pins (inverted stimulus out, masked response in).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start after reset; outputs at reset values
// S_SETTLE  | stimulus applied, counting SETTLE cycles for the project to respond
// S_CAPTURE | fold response into MISR, advance LFSR, count the vector
// S_DONE    | run complete; signature and stimulus hold until the next start

module tt_pin_exerciser #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int unsigned SETTLE      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    output logic [7:0]  stim_ui,
    input  logic [7:0]  resp_uo,
`ifdef PIN_EXERCISER_UIO_EN
    output logic [7:0]  stim_uio,
    input  logic [7:0]  resp_uio,
    input  logic [7:0]  resp_uio_oe,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [15:0] vec_count
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 01.
    localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  settle_cnt;
    logic        launch;
    logic        capture;
    logic        last_vec;
    logic [15:0] misr_in;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] din);
        return {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ din;
    endfunction

`ifdef PIN_EXERCISER_UIO_EN
    assign misr_in = {resp_uio & resp_uio_oe, resp_uo};
`else
    assign misr_in = {8'h00, resp_uo};
`endif

    assign last_vec = (vec_count == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        capture  = 1'b0;
        if (ena) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        launch   = 1'b1;
                        state_nx = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state_nx = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    capture  = 1'b1;
                    state_nx = last_vec ? S_DONE : S_SETTLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Settle timer is held at its load value outside S_SETTLE so every entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (ena) begin
            if (state != S_SETTLE) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_ui   <= 8'h00;
            signature <= 16'h0000;
            vec_count <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (launch) begin
            stim_ui   <= SEED_EFF;
            signature <= 16'h0000;
            vec_count <= 16'h0000;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (capture) begin
            stim_ui   <= lfsr_next(stim_ui);
            signature <= misr_next(signature, misr_in);
            vec_count <= vec_count + 16'd1;
            if (last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

`ifdef PIN_EXERCISER_UIO_EN
    // Kept as its own register so the pin is driven straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_uio <= 8'hFF;
        end else if (launch) begin
            stim_uio <= ~SEED_EFF;
        end else if (capture) begin
            stim_uio <= ~lfsr_next(stim_ui);
        end
    end
`endif

endmodule

// File: tb/tb_tt_pin_exerciser.sv
// Directed self-checking bench for tt_pin_exerciser: three instances with different run lengths and settle times.
module tb_tt_pin_exerciser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  resp_val = 8'h00;
    logic        resp_pat = 1'b0;
    logic [7:0]  resp_uo;

    logic [7:0]  stim_a, stim_b, stim_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [15:0] sig_a, sig_b, sig_c;
    logic [15:0] vc_a, vc_b, vc_c;
`ifdef PIN_EXERCISER_UIO_EN
    logic [7:0]  resp_uio = 8'hFF;
    logic [7:0]  resp_uio_oe = 8'h00;
    logic [7:0]  uio_a, uio_b, uio_c;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] sig_model [0:256];
    logic [7:0]  stim_end;

    always #5 clk = ~clk;

    // Stand-in user project: response is a fixed scramble of the stimulus.
    assign resp_uo = resp_pat ? (stim_a ^ 8'h3C) : resp_val;

    tt_pin_exerciser #(.NUM_VECTORS(256), .SEED(8'hA5), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .stim_ui(stim_a), .resp_uo(resp_uo),
`ifdef PIN_EXERCISER_UIO_EN
        .stim_uio(uio_a), .resp_uio(resp_uio), .resp_uio_oe(resp_uio_oe),
`endif
        .busy(busy_a), .done(done_a), .signature(sig_a), .vec_count(vc_a));

    tt_pin_exerciser #(.NUM_VECTORS(1), .SEED(8'hA5), .SETTLE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .stim_ui(stim_b), .resp_uo(resp_uo),
`ifdef PIN_EXERCISER_UIO_EN
        .stim_uio(uio_b), .resp_uio(resp_uio), .resp_uio_oe(resp_uio_oe),
`endif
        .busy(busy_b), .done(done_b), .signature(sig_b), .vec_count(vc_b));

    tt_pin_exerciser #(.NUM_VECTORS(2), .SEED(8'hA5), .SETTLE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .stim_ui(stim_c), .resp_uo(resp_uo),
`ifdef PIN_EXERCISER_UIO_EN
        .stim_uio(uio_c), .resp_uio(resp_uio), .resp_uio_oe(resp_uio_oe),
`endif
        .busy(busy_c), .done(done_c), .signature(sig_c), .vec_count(vc_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_lfsr(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return (s << 1) | {7'b0, fb};
    endfunction

    function automatic logic [15:0] model_misr(input logic [15:0] sig, input logic [7:0] d);
        logic [15:0] r;
        r = sig << 1;
        if (sig[15]) r = r ^ 16'h1021;
        return r ^ {8'h00, d};
    endfunction

    // Launches a run on all instances and follows u_a until done (bounded).
    task automatic run_a(input int ena_gap_at, input int start_at,
                         output int done_edge, output int busy_cnt);
        int e;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        busy_cnt = 0;
        done_edge = -1;
        while (e < 2000 && done_edge < 0) begin
            if (busy_a) busy_cnt++;
            if (e == start_at) start = 1'b1;
            if (e == ena_gap_at) ena = 1'b0;
            if (ena_gap_at >= 0 && e == ena_gap_at + 5) begin
                ena = 1'b1;
                chk("freeze_sig", sig_a, sig_model[100]);
                chk("freeze_vc", vc_a, 32'd100);
            end
            tick();
            e++;
            start = 1'b0;
            if (done_a) done_edge = e;
        end
        chk("run_timeout", (done_edge >= 0), 1);
    endtask

    initial begin
        int de, bc;
        logic [7:0] s;

        s = 8'hA5;
        sig_model[0] = 16'h0000;
        for (int k = 1; k <= 256; k++) begin
            sig_model[k] = model_misr(sig_model[k-1], s ^ 8'h3C);
            s = model_lfsr(s);
        end
        stim_end = s;

        // Reset with random inputs
        repeat (4) begin
            start = 1'($urandom);
            ena = 1'($urandom);
            resp_val = 8'($urandom);
            tick();
        end
        chk("rst_stim", stim_a, 8'h00);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_sig", sig_a, 16'h0000);
        chk("rst_vc", vc_a, 16'h0000);
`ifdef PIN_EXERCISER_UIO_EN
        chk("rst_uio", uio_a, 8'hFF);
`endif

        start = 1'b0;
        ena = 1'b1;
        resp_val = 8'h01;
        rst_n = 1'b1;
        tick();

        // Stimulus sequence and short runs
        start = 1'b1;
        tick();                       // edge 0
        start = 1'b0;
        chk("seq_0", stim_a, 8'hA5);
        chk("busy_0", busy_a, 1);
        tick();                       // edge 1
        chk("n1_done_early", done_b, 0);
        tick();                       // edge 2
        chk("seq_1", stim_a, 8'h4A);
        chk("n1_done", done_b, 1);
        chk("n1_busy", busy_b, 0);
        chk("n1_sig", sig_b, 16'h0001);
        tick(); tick();               // edge 4
        chk("seq_2", stim_a, 8'h95);
        tick(); tick();               // edge 6
        chk("seq_3", stim_a, 8'h2A);
        tick();                       // edge 7
        chk("n2_done_early", done_c, 0);
        tick();                       // edge 8
        chk("n2_done", done_c, 1);
        chk("n2_sig", sig_c, 16'h0003);
        chk("n2_vc", vc_c, 16'd2);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("midrst_stim", stim_a, 8'h00);
        chk("midrst_sig", sig_a, 16'h0000);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_vc", vc_a, 16'h0000);
        chk("midrst_done_c", done_c, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Zero response, full 256-vector run
        resp_val = 8'h00;
        run_a(-1, -1, de, bc);
        chk("zero_done_edge", de, 512);
        chk("zero_busy_cycles", bc, 512);
        chk("zero_sig", sig_a, 16'h0000);
        chk("zero_vc", vc_a, 16'd256);
        repeat (3) tick();
        chk("done_hold", done_a, 1);
        chk("done_stim_hold", stim_a, stim_end);

        // Scrambled response with a stray start mid-run
        resp_pat = 1'b1;
        run_a(-1, 100, de, bc);
        chk("pat_done_edge", de, 512);
        chk("pat_sig", sig_a, sig_model[256]);

        // Enable gap of 5 cycles
        run_a(200, -1, de, bc);
        chk("gap_done_edge", de, 517);
        chk("gap_busy_cycles", bc, 517);
        chk("gap_sig", sig_a, sig_model[256]);

        // Reset mid-run, then restart reproduces the golden signature
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (150) tick();
        rst_n = 1'b0;
        #1;
        chk("rerun_rst_sig", sig_a, 16'h0000);
        chk("rerun_rst_busy", busy_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_a(-1, -1, de, bc);
        chk("rerun_done_edge", de, 512);
        chk("rerun_sig", sig_a, sig_model[256]);

`ifdef PIN_EXERCISER_UIO_EN
        resp_pat = 1'b0;
        resp_val = 8'h00;
        resp_uio = 8'hFF;
        resp_uio_oe = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("uio_stim", uio_b, 8'h5A);
        tick(); tick();
        chk("uio_done", done_b, 1);
        chk("uio_sig", sig_b, 16'hFF00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
